sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Read-only arbiter sharing the single 16-bit asynchronous SRAM between two requesters. The audio sample fetcher feeding the DAC path has priority. The chart/note fetcher used by game logic is the second requester. The arbiter owns all SRAM pins, sequences each access with a programmable number of wait states, and returns the latched read word with a one-cycle acknowledge per port.

## Interface
- WAIT_CYCLES, 2: cycles OE_N/CE_N held low before DQ is sampled; legal range 1..15.
- STARVE_LIMIT, 4: consecutive audio grants allowed while a chart request waits; used only with the guard macro.
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-low reset.
- A_REQ  in  1  audio read request, level, held until A_ACK.
- A_ADDR  in  20  audio word address; must be stable while A_REQ is high.
- A_ACK  out  1  one-cycle pulse; A_DATA valid.
- A_DATA  out  16  last audio read word; held between acks.
- C_REQ, C_ADDR, C_ACK, C_DATA: chart port; same widths and rules as the audio port.
- BUSY  out  1  high while in READ or ACK.
- SRAM_DQ  inout  16  always driven high-Z.
- SRAM_ADDR  out  20  latched access address.
- SRAM_CE_N, SRAM_OE_N  out  1  low only in READ.
- SRAM_WE_N  out  1  constant 1.
- SRAM_UB_N, SRAM_LB_N  out  1  constant 0.

## Operation
- States: IDLE, READ, ACK.
- IDLE, no request: stay in IDLE.
- IDLE, any request: record the winner (OWNER), latch the winner's address into SRAM_ADDR, set counter to WAIT_CYCLES-1, go to READ.
- READ: CE_N=OE_N=0. Counter decrements each cycle. When counter==0, capture SRAM_DQ into OWNER's data register and go to ACK.
- ACK: pulse OWNER's ACK for 1 cycle, return to IDLE. The other port's data register is unchanged.
- Arbitration in IDLE: if A_REQ is high, audio wins; otherwise chart wins. If both are high, audio wins.
- Request address or REQ changes during READ are ignored. The access completes and ACK still pulses. A requester that dropped REQ ignores that ACK.
- REQ still high in the cycle after ACK is a new request, evaluated in IDLE.
- Reset values (asserted asynchronously, including mid-access): state IDLE, CE_N=OE_N=1, SRAM_ADDR=0, A_ACK=C_ACK=0, A_DATA=C_DATA=0, BUSY=0, counter=0, starve count=0. An aborted access produces no ACK.
- A deasserted RESET is synchronised internally. State first advances on the second CLK edge after release.

## Timing
- REQ sampled high at edge t in IDLE:
  - SRAM_ADDR valid and CE_N/OE_N low from t+1 through t+WAIT_CYCLES.
  - DQ captured at edge t+WAIT_CYCLES+1.
  - ACK high in cycle t+WAIT_CYCLES+1.
  - Back in IDLE at t+WAIT_CYCLES+2.
- Read latency from sampling edge: WAIT_CYCLES+1 cycles. Minimum access period: WAIT_CYCLES+2 cycles.
- All outputs are registered or pure state decodes; no combinational path from REQ to SRAM pins or ACK.
- SRAM_ADDR changes only on the IDLE->READ edge, so it is stable across the whole OE_N-low window.
- CE_N/OE_N deassert on the same edge that captures DQ.

## Configuration
- SRAM_ARB_STARVE_GUARD_EN defined:
  - A starve counter increments on each audio grant made while C_REQ is high.
  - It clears on any chart grant, or when C_REQ is low in IDLE.
  - When the counter equals STARVE_LIMIT and both requests are pending in IDLE, chart wins.
- Not defined: strict audio priority, and the starve counter is not synthesised.

## Test plan
- Reset, WAIT_CYCLES=2, no requests -> CE_N=OE_N=WE_N=1, UB_N=LB_N=0, ACKs 0, data 0, BUSY 0, DQ high-Z.
- A_REQ at edge t, A_ADDR=20'h00010, SRAM model returns 16'hBEEF -> CE_N/OE_N low for cycles t+1..t+2, A_ACK pulse at t+3, A_DATA=16'hBEEF, C_DATA still 0.
- A_REQ and C_REQ high together, addresses 20'h00001 and 20'h80000 -> audio acked first. Chart address on SRAM_ADDR immediately after return to IDLE. C_ACK 4 cycles after A_ACK.
- Continuous A_REQ and C_REQ, guard macro defined, STARVE_LIMIT=4 -> grant order A,A,A,A,C repeating. Guard macro undefined -> C never acked.
- RESET low during READ -> CE_N/OE_N high immediately, no ACK. After release, pending A_REQ completes normally with correct data.
- C_ADDR changed from 20'h00100 to 20'h00200 during READ -> SRAM_ADDR stays 20'h00100 and C_DATA holds that word.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-port read-only arbiter for a 16-bit asynchronous SRAM; audio port has priority.
// Define SRAM_ARB_STARVE_GUARD_EN to let a waiting chart request win after STARVE_LIMIT audio grants.
module sram_arbiter #(
   parameter int unsigned WAIT_CYCLES  = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        A_REQ,
   input  logic [19:0] A_ADDR,
   output logic        A_ACK,
   output logic [15:0] A_DATA,
   input  logic        C_REQ,
   input  logic [19:0] C_ADDR,
   output logic        C_ACK,
   output logic [15:0] C_DATA,
   output logic        BUSY,
   inout  wire  [15:0] SRAM_DQ,
   output logic [19:0] SRAM_ADDR,
   output logic        SRAM_CE_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_WE_N,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N
);

   if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15 || STARVE_LIMIT > 255) begin : gen_bad_param
      $error("sram_arbiter: parameter out of range");
   end

   typedef enum logic [1:0] {StIdle, StRead, StAck} state_t;

   localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES - 1);

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic        owner_c_q;
   logic        run_q;
   logic        grant_c;

   // Release of RESET is retimed so the FSM starts on the second edge after it.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         run_q <= 1'b0;
      end else begin
         run_q <= 1'b1;
      end
   end

`ifdef SRAM_ARB_STARVE_GUARD_EN
   localparam logic [7:0] StarveMax = 8'(STARVE_LIMIT);

   logic [7:0] starve_q;

   assign grant_c = C_REQ && (!A_REQ || (starve_q == StarveMax));

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         starve_q <= 8'd0;
      end else if (run_q && state_q == StIdle) begin
         if (!C_REQ || grant_c) begin
            starve_q <= 8'd0;
         end else if (A_REQ) begin
            starve_q <= starve_q + 8'd1;
         end
      end
   end
`else
   assign grant_c = !A_REQ;
`endif

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q   <= StIdle;
         cnt_q     <= 4'd0;
         owner_c_q <= 1'b0;
         SRAM_ADDR <= 20'd0;
         SRAM_CE_N <= 1'b1;
         SRAM_OE_N <= 1'b1;
         A_ACK     <= 1'b0;
         C_ACK     <= 1'b0;
         A_DATA    <= 16'd0;
         C_DATA    <= 16'd0;
      end else if (run_q) begin
         unique case (state_q)
            StIdle: begin
               if (A_REQ || C_REQ) begin
                  owner_c_q <= grant_c;
                  SRAM_ADDR <= grant_c ? C_ADDR : A_ADDR;
                  cnt_q     <= WaitInit;
                  SRAM_CE_N <= 1'b0;
                  SRAM_OE_N <= 1'b0;
                  state_q   <= StRead;
               end
            end
            StRead: begin
               if (cnt_q == 4'd0) begin
                  if (owner_c_q) begin
                     C_DATA <= SRAM_DQ;
                     C_ACK  <= 1'b1;
                  end else begin
                     A_DATA <= SRAM_DQ;
                     A_ACK  <= 1'b1;
                  end
                  SRAM_CE_N <= 1'b1;
                  SRAM_OE_N <= 1'b1;
                  state_q   <= StAck;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            StAck: begin
               A_ACK   <= 1'b0;
               C_ACK   <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign BUSY      = (state_q != StIdle);
   assign SRAM_DQ   = 16'bz;
   assign SRAM_WE_N = 1'b1;
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter (WAIT_CYCLES=2, STARVE_LIMIT=4) with a tiny SRAM read model.
module tb_sram_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        a_req = 1'b0, c_req = 1'b0;
   logic [19:0] a_addr = 20'd0, c_addr = 20'd0;
   logic        a_ack, c_ack, busy;
   logic [15:0] a_data, c_data;
   wire  [15:0] sram_dq;
   logic [19:0] sram_addr;
   logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

   int n_vec = 0;
   int n_err = 0;

   function automatic logic [15:0] mem_word(input logic [19:0] a);
      case (a)
         20'h00010: return 16'hBEEF;
         20'h00001: return 16'h1111;
         20'h80000: return 16'h8000;
         20'h00100: return 16'hC100;
         20'h00200: return 16'hC200;
         default:   return a[15:0] ^ 16'hA5A5;
      endcase
   endfunction

   assign sram_dq = !sram_oe_n ? mem_word(sram_addr) : 16'h0000;

   sram_arbiter #(.WAIT_CYCLES(2), .STARVE_LIMIT(4)) dut (
      .CLK(clk), .RESET(rst_n),
      .A_REQ(a_req), .A_ADDR(a_addr), .A_ACK(a_ack), .A_DATA(a_data),
      .C_REQ(c_req), .C_ADDR(c_addr), .C_ACK(c_ack), .C_DATA(c_data),
      .BUSY(busy), .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr),
      .SRAM_CE_N(sram_ce_n), .SRAM_OE_N(sram_oe_n), .SRAM_WE_N(sram_we_n),
      .SRAM_UB_N(sram_ub_n), .SRAM_LB_N(sram_lb_n)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int seq[$];
      int a_cnt, c_cnt;
      logic found;

      // Reset state
      cyc(3);
      check("rst_ce_n", sram_ce_n, 1);
      check("rst_oe_n", sram_oe_n, 1);
      check("rst_we_n", sram_we_n, 1);
      check("rst_ub_n", sram_ub_n, 0);
      check("rst_lb_n", sram_lb_n, 0);
      check("rst_acks", {a_ack, c_ack}, 0);
      check("rst_a_data", a_data, 0);
      check("rst_c_data", c_data, 0);
      check("rst_busy", busy, 0);
      check("rst_addr", sram_addr, 0);
      rst_n = 1'b1;
      cyc(3);
      check("idle_ce_n", sram_ce_n, 1);
      check("idle_busy", busy, 0);

      // Single audio read
      a_req = 1'b1; a_addr = 20'h00010;
      cyc();
      check("a1_ce_n", sram_ce_n, 0);
      check("a1_oe_n", sram_oe_n, 0);
      check("a1_addr", sram_addr, 20'h00010);
      check("a1_busy", busy, 1);
      check("a1_ack_early", a_ack, 0);
      cyc();
      check("a2_oe_n", sram_oe_n, 0);
      check("a2_ack_early", a_ack, 0);
      cyc();
      check("a3_ack", a_ack, 1);
      check("a3_oe_n", sram_oe_n, 1);
      check("a3_data", a_data, 16'hBEEF);
      check("a3_c_data", c_data, 0);
      check("a3_c_ack", c_ack, 0);
      a_req = 1'b0;
      cyc();
      check("a4_ack_off", a_ack, 0);
      check("a4_busy", busy, 0);

      // Simultaneous requests: audio first, chart four cycles later
      a_req = 1'b1; a_addr = 20'h00001;
      c_req = 1'b1; c_addr = 20'h80000;
      cyc();
      check("b1_addr", sram_addr, 20'h00001);
      cyc(2);
      check("b3_a_ack", a_ack, 1);
      check("b3_c_ack", c_ack, 0);
      check("b3_a_data", a_data, 16'h1111);
      a_req = 1'b0;
      cyc();
      check("b4_idle", busy, 0);
      cyc();
      check("b5_c_addr", sram_addr, 20'h80000);
      check("b5_oe_n", sram_oe_n, 0);
      cyc(2);
      check("b7_c_ack", c_ack, 1);
      check("b7_c_data", c_data, 16'h8000);
      check("b7_a_data", a_data, 16'h1111);
      c_req = 1'b0;
      cyc(2);

      // Continuous requests from both ports
      a_req = 1'b1; a_addr = 20'h00030;
      c_req = 1'b1; c_addr = 20'h00040;
`ifdef SRAM_ARB_STARVE_GUARD_EN
      for (int i = 0; i < 80 && seq.size() < 10; i++) begin
         cyc();
         if (a_ack) begin
            seq.push_back(0);
            check("stv_a_data", a_data, mem_word(20'h00030));
         end
         if (c_ack) begin
            seq.push_back(1);
            check("stv_c_data", c_data, mem_word(20'h00040));
         end
      end
      check("stv_count", seq.size(), 10);
      for (int i = 0; i < seq.size(); i++) begin
         check($sformatf("stv_grant%0d", i), seq[i], (i % 5 == 4) ? 1 : 0);
      end
`else
      a_cnt = 0; c_cnt = 0;
      for (int i = 0; i < 60; i++) begin
         cyc();
         if (a_ack) a_cnt++;
         if (c_ack) c_cnt++;
      end
      check("prio_no_c_ack", c_cnt, 0);
      check("prio_a_acks", (a_cnt >= 14) ? 1 : 0, 1);
      check("prio_a_data", a_data, mem_word(20'h00030));
`endif
      a_req = 1'b0; c_req = 1'b0;
      cyc(8);

      // Reset asserted in the middle of a read
      a_req = 1'b1; a_addr = 20'h00055;
      cyc();
      check("r1_oe_n", sram_oe_n, 0);
      rst_n = 1'b0;
      #1;
      check("r1_ce_n_abort", sram_ce_n, 1);
      check("r1_oe_n_abort", sram_oe_n, 1);
      check("r1_busy_abort", busy, 0);
      check("r1_a_data_clr", a_data, 0);
      found = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         if (a_ack) found = 1'b1;
      end
      check("r1_no_ack", found, 0);
      rst_n = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
         cyc();
         if (a_ack) found = 1'b1;
      end
      check("r2_ack", found, 1);
      check("r2_data", a_data, 16'hA5F0);
      a_req = 1'b0;
      cyc(2);

      // Chart address changing during READ is ignored
      c_req = 1'b1; c_addr = 20'h00100;
      cyc();
      check("c1_addr", sram_addr, 20'h00100);
      c_addr = 20'h00200;
      cyc();
      check("c2_addr_hold", sram_addr, 20'h00100);
      cyc();
      check("c3_ack", c_ack, 1);
      check("c3_data", c_data, 16'hC100);
      c_req = 1'b0;
      cyc();
      check("c4_addr_hold", sram_addr, 20'h00100);
      check("c4_ack_off", c_ack, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
